// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and sizing helpers for the sequential multiplier
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Iteration counter width; never below one bit so narrow builds still elaborate.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/rca_n.sv
// rtl/rca_n.sv - parametrised N-bit ripple-carry adder with carry in/out
module rca_n #(
   parameter int N = 4
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_cin,
   output logic [N-1:0] o_sum,
   output logic         o_cout
);

   logic w_c;

   always_comb begin
      o_sum = '0;
      w_c   = i_cin;
      for (int i = 0; i < N; i++) begin
         o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
         w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
      end
      o_cout = w_c;
   end

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - WIDTH-cycle shift-add multiplier, signed or unsigned per operation
module seq_multiplier
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = cnt_width(WIDTH);
   localparam int AW = 2 * WIDTH;

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [AW-1:0]    r_acc;
   logic [AW-1:0]    r_product;
   logic [CW-1:0]    r_cnt;
   logic             r_neg;

   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH-1:0] w_addend;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic [AW-1:0]    w_acc_next;
   logic             w_accept;
   logic             w_last;

   // Magnitudes fit in WIDTH unsigned bits, including the most negative operand.
   assign w_a_mag  = (signed_mode && a[WIDTH-1]) ? -a : a;
   assign w_b_mag  = (signed_mode && b[WIDTH-1]) ? -b : b;
   assign w_addend = r_mplier[0] ? r_mcand : '0;

   rca_n #(.N(WIDTH)) u_rca (
      .i_a    (r_acc[AW-1:WIDTH]),
      .i_b    (w_addend),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // The adder carry becomes the new accumulator MSB after the right shift.
   assign w_acc_next = AW'({w_cout, w_sum, r_acc[WIDTH-1:0]} >> 1);
   assign product    = r_product;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept     = 1'b1;
               w_next_state = CALC;
            end
         end
         CALC: begin
            if (r_cnt == CW'(WIDTH - 1)) begin
               w_last       = 1'b1;
               w_next_state = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_product <= '0;
         r_cnt     <= '0;
         r_neg     <= 1'b0;
      end else if (w_accept) begin
         r_mcand  <= w_a_mag;
         r_mplier <= w_b_mag;
         r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (r_state == CALC) begin
         r_acc    <= w_acc_next;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (w_last) begin
            r_product <= r_neg ? -w_acc_next : w_acc_next;
         end
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier at WIDTH=4 and WIDTH=8
module tb_seq_multiplier;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] in_valid;
   logic [1:0] out_ready;
   logic [1:0] sm;
   logic [1:0] ir;
   logic [1:0] ov;
   logic [7:0] av [2];
   logic [7:0] bv [2];
   logic [7:0] p4;
   logic [15:0] p8;

   bit          m_busy [2];
   bit          m_vld  [2];
   int          m_left [2];
   logic [15:0] m_exp  [2];
   logic [15:0] m_prod [2];
   bit          lit_has [2];
   logic [15:0] lit_exp [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_multiplier #(.WIDTH(4)) u_dut4 (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid[0]),
      .in_ready    (ir[0]),
      .a           (av[0][3:0]),
      .b           (bv[0][3:0]),
      .signed_mode (sm[0]),
      .out_valid   (ov[0]),
      .out_ready   (out_ready[0]),
      .product     (p4)
   );

   seq_multiplier #(.WIDTH(8)) u_dut8 (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid[1]),
      .in_ready    (ir[1]),
      .a           (av[1]),
      .b           (bv[1]),
      .signed_mode (sm[1]),
      .out_valid   (ov[1]),
      .out_ready   (out_ready[1]),
      .product     (p8)
   );

   function automatic logic [15:0] ref_mul(input int w, input logic [7:0] a, input logic [7:0] b, input bit s);
      longint one;
      longint x;
      longint y;
      longint p;
      one = 1;
      x = longint'(a) & ((one << w) - 1);
      y = longint'(b) & ((one << w) - 1);
      if (s && x[w-1]) x = x - (one << w);
      if (s && y[w-1]) y = y - (one << w);
      p = (x * y) & ((one << (2 * w)) - 1);
      return p[15:0];
   endfunction

   function automatic logic [15:0] pv(input int d);
      return (d == 0) ? {8'h00, p4} : p8;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_model
      localparam int W = (g == 0) ? 4 : 8;
      always @(posedge clk or posedge rst) begin
         if (rst) begin
            m_busy[g] <= 1'b0;
            m_vld[g]  <= 1'b0;
            m_left[g] <= 0;
            m_exp[g]  <= '0;
            m_prod[g] <= '0;
         end else if (m_busy[g]) begin
            m_left[g] <= m_left[g] - 1;
            if (m_left[g] == 1) begin
               m_busy[g] <= 1'b0;
               m_vld[g]  <= 1'b1;
               m_prod[g] <= m_exp[g];
            end
         end else if (m_vld[g]) begin
            if (out_ready[g]) m_vld[g] <= 1'b0;
         end else if (in_valid[g]) begin
            m_busy[g] <= 1'b1;
            m_left[g] <= W;
            m_exp[g]  <= ref_mul(W, av[g], bv[g], sm[g]);
         end
      end
   end

   task automatic chk(input string nm, input int d, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s dut%0d actual=%h required=%h at %0t", nm, d, got, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            chk("in_ready", d, 16'(ir[d]), 16'(!(m_busy[d] || m_vld[d])));
            chk("out_valid", d, 16'(ov[d]), 16'(m_vld[d]));
            chk("product", d, pv(d), m_prod[d]);
            if (ov[d] && out_ready[d] && lit_has[d]) chk("literal", d, pv(d), lit_exp[d]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int d);
      int n;
      n = 0;
      while (!ov[d] && n < 50) begin
         tick();
         n++;
      end
      if (!ov[d]) begin
         $display("FAIL timeout dut%0d out_valid actual=0 required=1", d);
         $fatal(1, "out_valid never rose");
      end
   endtask

   task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b, input bit s,
                         input bit has, input logic [15:0] lit);
      lit_has[d]   = has;
      lit_exp[d]   = lit;
      av[d]        = a;
      bv[d]        = b;
      sm[d]        = s;
      in_valid[d]  = 1'b1;
      out_ready[d] = 1'b1;
      tick();
      in_valid[d] = 1'b0;
      wait_valid(d);
      tick();
   endtask

   initial begin
      int n;
      in_valid  = '0;
      out_ready = '0;
      sm        = '0;
      for (int d = 0; d < 2; d++) begin
         av[d]      = '0;
         bv[d]      = '0;
         lit_has[d] = 1'b0;
         lit_exp[d] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      tick();

      run_op(0, 8'hF, 8'hF, 1'b0, 1'b1, 16'h00E1);
      run_op(0, 8'h8, 8'h8, 1'b1, 1'b1, 16'h0040);
      run_op(0, 8'h8, 8'h7, 1'b1, 1'b1, 16'h00C8);
      run_op(0, 8'h3, 8'hF, 1'b1, 1'b1, 16'h00FD);
      run_op(0, 8'hF, 8'hF, 1'b1, 1'b1, 16'h0001);
      run_op(0, 8'h0, 8'h0, 1'b0, 1'b1, 16'h0000);
      run_op(1, 8'h00, 8'hFF, 1'b0, 1'b1, 16'h0000);
      run_op(1, 8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFE01);
      run_op(1, 8'h80, 8'h80, 1'b1, 1'b1, 16'h4000);
      run_op(1, 8'h80, 8'h7F, 1'b1, 1'b1, 16'hC080);
      run_op(1, 8'hFF, 8'h01, 1'b1, 1'b1, 16'hFFFF);

      // Backpressure: result must hold while new operands are waved at the input.
      lit_has[0] = 1'b1;
      lit_exp[0] = 16'h000F;
      av[0] = 8'h5;
      bv[0] = 8'h3;
      sm[0] = 1'b0;
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      wait_valid(0);
      for (int i = 0; i < 10; i++) begin
         in_valid[0] = i[0];
         av[0] = 8'($urandom);
         bv[0] = 8'($urandom);
         sm[0] = 1'($urandom);
         tick();
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      tick();

      // Asynchronous reset two CALC edges into an operation.
      lit_has[0] = 1'b0;
      av[0] = 8'h9;
      bv[0] = 8'hB;
      sm[0] = 1'b0;
      in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      tick();
      tick();
      #1 rst = 1'b1;
      #6 rst = 1'b0;
      tick();
      run_op(0, 8'h6, 8'h7, 1'b0, 1'b1, 16'h002A);

      for (int i = 0; i < 200; i++) run_op(0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), i[0], 1'b0, 16'h0);
      for (int i = 0; i < 1000; i++) run_op(1, 8'($urandom), 8'($urandom), i[0], 1'b0, 16'h0);

      // Back-to-back with both handshakes held high.
      for (int d = 0; d < 2; d++) begin
         lit_has[d]   = 1'b0;
         out_ready[d] = 1'b1;
         in_valid[d]  = 1'b1;
         for (int i = 0; i < 60; i++) begin
            if (ir[d]) begin
               av[d] = 8'($urandom);
               bv[d] = 8'($urandom);
               sm[d] = 1'($urandom);
            end
            tick();
         end
         in_valid[d] = 1'b0;
         n = 0;
         while (!ir[d] && n < 50) begin
            tick();
            n++;
         end
      end

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
